// File: rtl/fp32_div_sequencer.sv
// Sequencer around the iterative SRT FP32 divide core: operand handshake, IEEE special-case
// bypass, core init/iteration window and result capture with an output handshake.
module fp32_div_sequencer #(
    parameter int CORE_CYCLES = 14,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    output logic        core_rst_n,
    input  logic [31:0] core_quotient,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CORE_CYCLES);
    localparam logic [CNT_W-1:0] MAX_CNT  = '1;
    localparam logic [31:0]      QNAN     = 32'h7FC00000;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       dividend_q, dividend_d;
    logic [31:0]       divisor_q, divisor_d;
    logic [31:0]       result_q, result_d;
    logic [2:0]        flags_q, flags_d;

    logic        aNan, bNan, aInf, bInf, aZero, bZero, aSnan, bSnan;
    logic        sign;
    logic        special;
    logic [31:0] aFlush, bFlush;
    logic [31:0] specResult;
    logic [2:0]  specFlags;

    // Denormals are treated as zero of the same sign everywhere downstream.
    always_comb begin
        aNan   = (&in_a[30:23]) && (|in_a[22:0]);
        bNan   = (&in_b[30:23]) && (|in_b[22:0]);
        aInf   = (&in_a[30:23]) && !(|in_a[22:0]);
        bInf   = (&in_b[30:23]) && !(|in_b[22:0]);
        aZero  = (in_a[30:23] == 8'h00);
        bZero  = (in_b[30:23] == 8'h00);
        aSnan  = aNan && !in_a[22];
        bSnan  = bNan && !in_b[22];
        sign   = in_a[31] ^ in_b[31];
        aFlush = aZero ? {in_a[31], 31'b0} : in_a;
        bFlush = bZero ? {in_b[31], 31'b0} : in_b;
        special = aNan || bNan || aInf || bInf || aZero || bZero;
    end

    // Flags are {invalid, div_by_zero, bypass}; branches follow IEEE priority.
    always_comb begin
        specResult = {sign, 31'b0};
        specFlags  = 3'b001;
        if (aNan || bNan) begin
            specResult = QNAN;
            specFlags  = {aSnan || bSnan, 2'b01};
        end else if ((aZero && bZero) || (aInf && bInf)) begin
            specResult = QNAN;
            specFlags  = 3'b101;
        end else if (aInf) begin
            specResult = {sign, 8'hFF, 23'b0};
            specFlags  = 3'b001;
        end else if (bZero) begin
            specResult = {sign, 8'hFF, 23'b0};
            specFlags  = 3'b011;
        end else begin
            specResult = {sign, 31'b0};
            specFlags  = 3'b001;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        result_d = specResult;
                        flags_d  = specFlags;
                        state_d  = DONE;
                    end else begin
                        dividend_d = aFlush;
                        divisor_d  = bFlush;
                        state_d    = INIT;
                    end
                end
            end
            INIT: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // The counter tracks the core's own iteration count, so it saturates rather than wraps.
                if (cnt_q != MAX_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == LAST_CNT) begin
                    result_d = core_quotient;
                    flags_d  = 3'b000;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    // The core is held in init only for the INIT cycle and during our own reset.
    assign core_rst_n    = !rst && (state_q != INIT);
    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign core_dividend = dividend_q;
    assign core_divisor  = divisor_q;
    assign out_result    = result_q;
    assign out_flags     = flags_q;

endmodule

// File: tb/tb_fp32_div_sequencer.sv
// Randomized bench for fp32_div_sequencer with a behavioural core stand-in and IEEE reference model.
module tb_fp32_div_sequencer;

    localparam int CORE_CYCLES = 14;
    localparam int C_ZERO = 0, C_FIN = 1, C_INF = 2, C_QNAN = 3, C_SNAN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [31:0] core_dividend, core_divisor, core_quotient;
    logic        core_rst_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int failures = 0;
    int coreCnt = 0;

    fp32_div_sequencer #(.CORE_CYCLES(CORE_CYCLES), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_rst_n(core_rst_n), .core_quotient(core_quotient),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Stand-in quotient: exact for the directed cases, a keyed mix otherwise.
    function automatic logic [31:0] coreFunc(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == b) return 32'h3F800000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
    endfunction

    // Core stand-in: result is only correct on the iteration where its counter reaches CORE_CYCLES.
    always @(posedge clk) begin
        if (!core_rst_n) coreCnt <= 0;
        else if (coreCnt < 1000) coreCnt <= coreCnt + 1;
    end

    always_comb begin
        core_quotient = coreFunc(core_dividend, core_divisor);
        if (coreCnt != CORE_CYCLES) core_quotient = core_quotient ^ 32'hDEADBEEF;
    end

    function automatic int opClass(input logic [31:0] x);
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) return C_INF;
            return x[22] ? C_QNAN : C_SNAN;
        end
        if (x[30:23] == 8'h00) return C_ZERO;
        return C_FIN;
    endfunction

    task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic [2:0] flags,
                            output int lat, output bit normal);
        int ca, cb;
        logic s;
        ca = opClass(a);
        cb = opClass(b);
        s = a[31] ^ b[31];
        lat = 1;
        normal = 1'b0;
        if (ca >= C_QNAN || cb >= C_QNAN) begin
            res = 32'h7FC00000;
            flags = {(ca == C_SNAN || cb == C_SNAN), 2'b01};
        end else if ((ca == C_ZERO && cb == C_ZERO) || (ca == C_INF && cb == C_INF)) begin
            res = 32'h7FC00000; flags = 3'b101;
        end else if (ca == C_INF) begin
            res = {s, 31'h7F800000}; flags = 3'b001;
        end else if (cb == C_ZERO) begin
            res = {s, 31'h7F800000}; flags = 3'b011;
        end else if (ca == C_ZERO || cb == C_INF) begin
            res = {s, 31'b0}; flags = 3'b001;
        end else begin
            res = coreFunc(a, b); flags = 3'b000; lat = CORE_CYCLES + 3; normal = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic waitInReady();
        int waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("inReadyWait", 32'(in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] expRes, held;
        logic [2:0]  expFlags;
        int expLat, lat, lowCnt;
        bit normal;
        refModel(a, b, expRes, expFlags, expLat, normal);
        waitInReady();
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        lat = 1;
        lowCnt = 0;
        while (!out_valid && lat < 60) begin
            if (!core_rst_n) lowCnt++;
            checkOutput("busyInReady", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("outValid", 32'(out_valid), 32'd1);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("result", out_result, expRes);
        checkOutput("flags", 32'(out_flags), 32'(expFlags));
        checkOutput("coreRstLowCycles", 32'(lowCnt), normal ? 32'd1 : 32'd0);
        if (normal) begin
            checkOutput("coreDividend", core_dividend, a);
            checkOutput("coreDivisor", core_divisor, b);
        end
        held = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("holdResult", out_result, held);
            checkOutput("holdFlags", 32'(out_flags), 32'(expFlags));
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdInReady", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("releaseValid", 32'(out_valid), 32'd0);
        checkOutput("releaseInReady", 32'(in_ready), 32'd1);
    endtask

    task automatic applyResetMidRun();
        int seen = 0;
        waitInReady();
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Index 1 is INIT; the run counter reads 7 eight cycles later.
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstCoreRstN", 32'(core_rst_n), 32'd0);
        checkOutput("rstOutResult", out_result, 32'd0);
        checkOutput("rstOutFlags", 32'(out_flags), 32'd0);
        checkOutput("rstDividend", core_dividend, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("noGhostResult", 32'(seen), 32'd0);
        applyStimulus(32'h3F800000, 32'h3F800000, 0);
    endtask

    function automatic logic [31:0] randOperand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0: return {s, 31'b0};
            1: return {s, 8'h00, 23'($urandom) | 23'h1};
            2: return {s, 8'hFF, 23'b0};
            3: return {s, 8'hFF, 1'b1, 22'($urandom)};
            4: return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutValid", 32'(out_valid), 32'd0);
        checkOutput("resetOutResult", out_result, 32'd0);
        checkOutput("resetOutFlags", 32'(out_flags), 32'd0);
        checkOutput("resetDividend", core_dividend, 32'd0);
        checkOutput("resetDivisor", core_divisor, 32'd0);
        checkOutput("resetCoreRstN", 32'(core_rst_n), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("resetInReady", 32'(in_ready), 32'd1);
        checkOutput("idleCoreRstN", 32'(core_rst_n), 32'd1);

        applyStimulus(32'h40C00000, 32'h40000000, 0);
        applyStimulus(32'h3F800000, 32'h00000000, 0);
        applyStimulus(32'h3F800000, 32'h80000000, 0);
        applyStimulus(32'h00000000, 32'h00000000, 0);
        applyStimulus(32'h7F800000, 32'hFF800000, 0);
        applyStimulus(32'h7F800001, 32'h3F800000, 0);
        applyStimulus(32'h7FC00001, 32'h3F800000, 0);
        applyStimulus(32'h40C00000, 32'h40000000, 10);
        applyStimulus(32'h00000001, 32'h3F800000, 0);
        applyStimulus(32'h3F800000, 32'h80000001, 0);
        applyStimulus(32'hFF800000, 32'h40000000, 2);
        applyStimulus(32'h40000000, 32'h7F800000, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(randOperand(), randOperand(), int'($urandom_range(0, 3)));
        end

        applyResetMidRun();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
